// File: rtl/poly_mod_sq_iter.sv
// Iterated modular squarer: loops one SQ_MODE core to compute x^(2^N) mod MODULUS.
// Optional checkpoint output is enabled by defining POLY_SQ_ITER_CKPT_EN.

module poly_mod_sq_core #(
    parameter int WORD_BITS = 16,
    parameter int NUM_WORDS = 16,
    parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = (256'd1 << 255) - 256'd10,
    parameter int REDUCTION_BITS = 9,
    parameter int I_WORD = NUM_WORDS + 1,
    parameter int COEF_BITS = WORD_BITS + 1,
    parameter int LAT = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_val,
    input  logic [I_WORD*COEF_BITS-1:0] i_dat,
    output logic                        o_val,
    output logic [I_WORD*COEF_BITS-1:0] o_dat
);
    localparam int DAT_W  = I_WORD * COEF_BITS;
    localparam int MOD_W  = WORD_BITS * NUM_WORDS;
    localparam int VAL_W  = WORD_BITS * I_WORD + COEF_BITS + 1;
    localparam int SQ_W   = 2 * VAL_W;
    localparam int HI_W   = SQ_W - MOD_W + 1;
    localparam int FOLD_W = HI_W + REDUCTION_BITS + 1;
    localparam logic [MOD_W-1:0] TOP_BIT = MOD_W'(1) << (MOD_W - 1);
    // MODULUS = 2^(MOD_W-1) - FOLD_C, so the high part folds back scaled by FOLD_C
    localparam logic [REDUCTION_BITS-1:0] FOLD_C = REDUCTION_BITS'(TOP_BIT - MODULUS);

    logic [VAL_W-1:0]  acc;
    logic [SQ_W-1:0]   sq;
    logic [FOLD_W-1:0] fold;
    logic [MOD_W-1:0]  rem;
    logic [DAT_W-1:0]  res;
    logic [LAT:1]      vld_pipe;
    logic [DAT_W-1:0]  dat_pipe [1:LAT];

    always_comb begin
        acc = '0;
        for (int i = 0; i < I_WORD; i++)
            acc = acc + (VAL_W'(i_dat[i*COEF_BITS +: COEF_BITS]) << (WORD_BITS * i));
        sq   = SQ_W'(acc) * SQ_W'(acc);
        fold = FOLD_W'(sq[SQ_W-1:MOD_W-1]) * FOLD_W'(FOLD_C) + FOLD_W'(sq[MOD_W-2:0]);
        rem  = MOD_W'(fold % FOLD_W'(MODULUS));
        res  = '0;
        for (int i = 0; i < NUM_WORDS; i++)
            res[i*COEF_BITS +: COEF_BITS] = COEF_BITS'(rem[i*WORD_BITS +: WORD_BITS]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            for (int i = 1; i <= LAT; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= i_val;
            dat_pipe[1] <= res;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign o_val = vld_pipe[LAT];
    assign o_dat = dat_pipe[LAT];
endmodule

module poly_mod_sq_iter #(
    parameter int WORD_BITS = 16,
    parameter int NUM_WORDS = 16,
    parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = (256'd1 << 255) - 256'd10,
    parameter int REDUCTION_BITS = 9,
    parameter int REDUN_WORD_BITS = 1,
    parameter int I_WORD = NUM_WORDS + 1,
    parameter int COEF_BITS = WORD_BITS + REDUN_WORD_BITS,
    parameter int IN_PIPES = 3,
    parameter int OUT_PIPES = 3,
    parameter int ITER_BITS = 32,
    parameter int CORE_LAT = 4
`ifdef POLY_SQ_ITER_CKPT_EN
    , parameter int CKPT_LOG = 10
`endif
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_val,
    output logic                        o_rdy,
    input  logic [I_WORD*COEF_BITS-1:0] i_dat,
    input  logic [ITER_BITS-1:0]        i_iter,
    output logic                        o_val,
    input  logic                        i_rdy,
    output logic [I_WORD*COEF_BITS-1:0] o_dat,
    output logic [ITER_BITS-1:0]        o_iter_cnt,
    output logic                        o_busy,
    output logic                        o_ckpt_val,
    output logic [I_WORD*COEF_BITS-1:0] o_ckpt_dat
);
    localparam int DAT_W = I_WORD * COEF_BITS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SQ    = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]           state;
    logic [ITER_BITS-1:0] n_reg, cnt_nxt;
    logic [IN_PIPES:1]    in_vld;
    logic [DAT_W-1:0]     in_dat [1:IN_PIPES];
    logic [OUT_PIPES:1]   out_vld;
    logic [DAT_W-1:0]     out_dat [1:OUT_PIPES];
    logic [DAT_W-1:0]     loop_q, core_idat, core_odat, launch_dat;
    logic                 accept, in_top, launch0, launch, iss_q, fin_q;
    logic                 core_ival, core_oval, cap;

    assign o_rdy      = (state == S_IDLE);
    assign o_busy     = (state != S_IDLE);
    assign accept     = i_val && o_rdy;
    assign in_top     = (state == S_LOAD) && in_vld[IN_PIPES];
    // N==0 skips the core and launches the operand straight into the output pipe
    assign launch0    = in_top && (n_reg == '0);
    assign launch     = launch0 || fin_q;
    assign launch_dat = launch0 ? in_dat[IN_PIPES] : loop_q;
    assign core_ival  = (in_top && (n_reg != '0)) || iss_q;
    assign core_idat  = iss_q ? loop_q : in_dat[IN_PIPES];
    assign cap        = (state == S_SQ) && core_oval;
    assign cnt_nxt    = o_iter_cnt + ITER_BITS'(1);

    poly_mod_sq_core #(
        .WORD_BITS(WORD_BITS), .NUM_WORDS(NUM_WORDS), .MODULUS(MODULUS),
        .REDUCTION_BITS(REDUCTION_BITS), .I_WORD(I_WORD), .COEF_BITS(COEF_BITS),
        .LAT(CORE_LAT)
    ) u_core (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_val(core_ival), .i_dat(core_idat),
        .o_val(core_oval), .o_dat(core_odat)
    );

`ifdef POLY_SQ_ITER_CKPT_EN
    localparam logic [ITER_BITS-1:0] CKPT_MASK = ITER_BITS'((64'd1 << CKPT_LOG) - 64'd1);
`else
    assign o_ckpt_val = 1'b0;
    assign o_ckpt_dat = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            n_reg      <= '0;
            o_iter_cnt <= '0;
            in_vld     <= '0;
            out_vld    <= '0;
            for (int i = 1; i <= IN_PIPES; i++) in_dat[i] <= '0;
            for (int i = 1; i <= OUT_PIPES; i++) out_dat[i] <= '0;
            loop_q     <= '0;
            iss_q      <= 1'b0;
            fin_q      <= 1'b0;
            o_val      <= 1'b0;
            o_dat      <= '0;
`ifdef POLY_SQ_ITER_CKPT_EN
            o_ckpt_val <= 1'b0;
            o_ckpt_dat <= '0;
`endif
        end else begin
            in_vld[1]  <= accept;
            in_dat[1]  <= i_dat;
            for (int i = 2; i <= IN_PIPES; i++) begin
                in_vld[i] <= in_vld[i-1];
                in_dat[i] <= in_dat[i-1];
            end
            out_vld[1] <= launch;
            out_dat[1] <= launch_dat;
            for (int i = 2; i <= OUT_PIPES; i++) begin
                out_vld[i] <= out_vld[i-1];
                out_dat[i] <= out_dat[i-1];
            end
            iss_q <= 1'b0;
            fin_q <= 1'b0;
`ifdef POLY_SQ_ITER_CKPT_EN
            o_ckpt_val <= 1'b0;
`endif
            case (state)
                S_IDLE: if (accept) begin
                    n_reg      <= i_iter;
                    o_iter_cnt <= '0;
                    state      <= S_LOAD;
                end
                S_LOAD: if (in_top) begin
                    if (n_reg == '0) begin
                        loop_q <= in_dat[IN_PIPES];
                        state  <= S_DRAIN;
                    end else begin
                        state  <= S_SQ;
                    end
                end
                S_SQ: if (cap) begin
                    loop_q     <= core_odat;
                    o_iter_cnt <= cnt_nxt;
                    if (cnt_nxt == n_reg) begin
                        fin_q <= 1'b1;
                        state <= S_DRAIN;
                    end else begin
                        iss_q <= 1'b1;
`ifdef POLY_SQ_ITER_CKPT_EN
                        if (((cnt_nxt & CKPT_MASK) == '0) && (cnt_nxt != '0)) begin
                            o_ckpt_val <= 1'b1;
                            o_ckpt_dat <= core_odat;
                        end
`endif
                    end
                end
                S_DRAIN: if (out_vld[OUT_PIPES]) begin
                    o_val <= 1'b1;
                    o_dat <= out_dat[OUT_PIPES];
                    state <= S_HOLD;
                end
                S_HOLD: if (i_rdy) begin
                    o_val <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/poly_mod_sq_iter.md
# poly_mod_sq_iter

Iterated modular squarer for the VDF datapath. Accepts one redundant-form operand and an iteration count N, then computes x^(2^N) mod MODULUS by looping the result of a single SQ_MODE poly_mod_mult core back into its input. It generalises the fixed-pipe squarer wrapper with parametrised input and output pipe depths, a ready/valid handshake on both sides, a programmable iteration count, and optional checkpoint output. It sits between the VDF control/host interface and the squaring core.

## Interface
- WORD_BITS, 16, bits per word
- NUM_WORDS, 16, words in MODULUS
- MODULUS, (1<<255)-10, modulus passed to core
- REDUCTION_BITS, 9, passed to core
- REDUN_WORD_BITS, 1, redundant bits per coefficient
- I_WORD, NUM_WORDS+1, coefficients per operand
- COEF_BITS, WORD_BITS+REDUN_WORD_BITS, coefficient width
- IN_PIPES, 3, register stages before core on first issue (>=1)
- OUT_PIPES, 3, register stages after final result (>=1)
- ITER_BITS, 32, width of iteration count
- CKPT_LOG, 10, checkpoint interval is 2^CKPT_LOG iterations (macro only)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_val  in  1  input operand valid
- o_rdy  out  1  block ready for new operand
- i_dat  in  I_WORD*COEF_BITS  operand, redundant form
- i_iter  in  ITER_BITS  squarings N, sampled with i_dat
- o_val  out  1  final result valid
- i_rdy  in  1  downstream ready
- o_dat  out  I_WORD*COEF_BITS  result, redundant form
- o_iter_cnt  out  ITER_BITS  squarings completed for current job
- o_busy  out  1  job in progress (not IDLE)
- o_ckpt_val  out  1  checkpoint pulse
- o_ckpt_dat  out  I_WORD*COEF_BITS  checkpoint value

## Operation
- States: IDLE, LOAD, SQ, DRAIN, HOLD.
- IDLE: o_rdy=1. Transfer on i_val&&o_rdy: capture i_iter into N reg, clear o_iter_cnt, push i_dat into input pipe -> LOAD.
- LOAD: wait IN_PIPES cycles; if N==0 -> DRAIN (core bypassed, operand goes to loop reg); else issue core i_val with pipe output -> SQ.
- SQ: on core o_val capture result into loop reg, o_iter_cnt++. If o_iter_cnt(new)==N -> DRAIN; else reissue loop reg to core next cycle.
- DRAIN: loop reg traverses OUT_PIPES stages -> HOLD.
- HOLD: o_val=1, o_dat stable. On i_rdy -> IDLE (o_rdy asserts next cycle; no same-cycle accept).
- Only one job in flight; i_val ignored while o_rdy=0.
- o_iter_cnt counts modulo 2^ITER_BITS; N=2^ITER_BITS-1 is legal.
- No normalisation; o_dat is core redundant form.

## Timing
- Reset: state IDLE; o_rdy=1; o_val, o_busy, o_ckpt_val=0; o_iter_cnt=0; o_dat, o_ckpt_dat=0; pipes/loop reg cleared, core in-flight valid discarded.
- Core latency L (fixed by core). Accept at cycle 0: first issue cycle IN_PIPES; issue k (k=0..N-1) at IN_PIPES+k*(L+1); final capture IN_PIPES+N*(L+1).
- o_val first high at IN_PIPES+N*(L+1)+OUT_PIPES+1; N=0: IN_PIPES+OUT_PIPES+1.
- o_busy high from cycle 1 until HOLD exits.
- i_rdy held low: o_val, o_dat held indefinitely; i_rdy high before HOLD has no effect.
- Reset mid-job: job discarded, no o_val, core output discarded.

## Configuration
- POLY_SQ_ITER_CKPT_EN defined: in SQ, when captured o_iter_cnt is a nonzero multiple of 2^CKPT_LOG, o_ckpt_val pulses 1 cycle the cycle after capture with o_ckpt_dat = loop reg; no checkpoint on final iteration (o_val covers it). No backpressure on checkpoint.
- Not defined: o_ckpt_val, o_ckpt_dat tied 0, no checkpoint logic; CKPT_LOG unused.

## Test plan
- i_dat=2, i_iter=3 -> o_val once at IN_PIPES+3*(L+1)+OUT_PIPES+1, o_dat normalises to 256, o_iter_cnt=3.
- i_dat=5, i_iter=0 -> o_dat=5 unchanged at IN_PIPES+OUT_PIPES+1, core i_val never asserted.
- Result in HOLD, i_rdy low 10 cycles -> o_val and o_dat constant 10 cycles; i_val pulses meanwhile ignored; o_rdy 1 cycle after i_rdy.
- i_rst_n low mid-SQ at iteration 2 of 5 -> all outputs reset value same cycle; no o_val after release; next job i_dat=3, i_iter=1 gives 9.
- Macro on, CKPT_LOG=1, i_dat=2, i_iter=5 -> o_ckpt_val after iterations 2 and 4 with values 16 and 65536; o_val final 2^32 mod MODULUS.
- Random x, N in 1..64, back-to-back jobs vs reference model -> all results match, no dropped/duplicate o_val.
